shiftcorr_pipe: RTL
===================

// Module: shiftcorr_pipe
// PURPOSE
//  Pipelined, parametrised post-normalisation shift correction for the FPU postprocessor.
//  Corrects LZA overshift of 0, 1 or 2 positions for FMA sums and handles the divsqrt quotient
//  range correction. Produces the corrected mantissa window and the result exponents.
//  Sits between the normalisation shifter and rounding, behind a valid/ready elastic
//  pipeline of STAGES registers, with a tag carried through and a synchronous flush.
// PARAMETERS
//  NSH     110  width of Shifted (normalisation shifter output)
//  NE      11   exponent field width; exponent busses are NE+2 bits
//  STAGES  2    register stages, legal range 1..4
//  TAGW    5    tag width carried alongside the data
//  (derived) CSH = NSH-3, the corrected mantissa window width
// PORTS
//  clk          in   1      clock
//  reset_n      in   1      asynchronous reset, active low
//  Flush        in   1      synchronous kill of all in-flight entries
//  InValid      in   1      input entry valid
//  InReady      out  1      stage 1 can accept this cycle
//  InTag        in   TAGW   tag, passed through unchanged
//  Op           in   2      00 FMA, 01 divsqrt, 10 passthrough (cvt), 11 reserved (treated as 10)
//  Shifted      in   NSH    normalisation shifter output
//  NormSumExp   in   NE+2   FMA exponent before correction
//  FmaPreSubnorm in  1      FMA result predicted subnormal before correction
//  FmaSZero     in   1      FMA sum is zero
//  DivUe        in   NE+2   divsqrt exponent
//  DivResSubnorm in  1      divsqrt result subnormal
//  DivShiftPos  in   1      subnormal divider shift amount positive
//  OutValid     out  1      output entry valid
//  OutReady     in   1      consumer accepts this cycle
//  OutTag       out  TAGW   tag of the output entry
//  Mf           out  CSH    corrected mantissa; the leading one is excluded
//  FmaMe        out  NE+2   corrected FMA exponent
//  Ue           out  NE+2   corrected divsqrt exponent
//  Corr         out  2      applied correction, 0..2 (for debug/perf)
// BEHAVIOUR
//  Correction (combinational, ahead of stage 1 register):
//   - Corr = 2 if Shifted[NSH-1]; else 1 if Shifted[NSH-2]; else 0.
//   - FMA window: Corr2 -> Shifted[NSH-2:2]; Corr1 -> Shifted[NSH-3:1]; Corr0 -> Shifted[NSH-4:0].
//   - Divsqrt with ~DivResSubnorm: same window as FMA.
//   - Divsqrt with DivResSubnorm: Shifted[NSH-1:3].
//   - Passthrough: Shifted[NSH-1:3]; FmaMe = 0; Ue = 0.
//   - ResSubnorm = FmaPreSubnorm & Corr==0 & ~Shifted[NSH-3].
//   - FmaMe = (NormSumExp + Corr + FmaPreSubnorm), forced to 0 if FmaSZero | ResSubnorm.
//     Arithmetic is modulo 2^(NE+2).
//   - Ue = 0 if DivResSubnorm & DivShiftPos; else DivUe - (Corr==0). Modulo 2^(NE+2).
//   - For non-divsqrt ops, Ue is computed but don't-care. For non-FMA ops, FmaMe is don't-care,
//     except passthrough, where it is 0.
//  Pipeline:
//   - Stage i has valid bit v[i]. adv[i] = v[i] & (i==last ? OutReady : ~v[i+1] | adv[i+1]).
//   - InReady = ~v[0] | adv[0]. The ready chain is combinational.
//   - Entry accepted when InValid & InReady. OutValid = v[last].
//   - Outputs are driven from the last stage registers.
//   - Latency STAGES cycles with no stall; throughput 1 entry/cycle; strict in-order delivery;
//     no drop and no duplication.
//   - While OutValid & ~OutReady, all output ports hold stable.
//   - Stalled stages hold their data; bubbles collapse, so a non-full pipe keeps accepting.
//   - Flush: all v[] cleared at the next edge. An input presented with Flush is not accepted,
//     and InReady is 0 in that cycle.
//  Reset (reset_n low, asynchronous):
//   - All v[] cleared; all data registers cleared to 0.
//   - OutValid=0, Mf=0, FmaMe=0, Ue=0, Corr=0, OutTag=0. InReady=1 after deassertion.
//   - Reset mid-operation discards all in-flight entries.
// TESTING (NSH=12, NE=4, CSH=9, STAGES=2 unless noted)
//  FMA Shifted=12'h805, NormSumExp=10 -> Corr=2, Mf=9'h001, FmaMe=12, 2 cycles later.
//  FMA Shifted=12'h2A5, NormSumExp=10 -> Corr=0, Mf=9'h0A5, FmaMe=10; with FmaPreSubnorm=1 and
//   Shifted=12'h0A5 -> FmaMe=0.
//  Divsqrt DivUe=5, Shifted=12'h400 -> Ue=5, Corr=1; Shifted=12'h200 -> Ue=4.
//   DivResSubnorm=DivShiftPos=1, Shifted=12'hFF8 -> Ue=0, Mf=9'h1FF.
//  Backpressure: OutReady=0 for 6 cycles, InValid=1 with tags 1,2,3 -> tags 1,2 accepted,
//   InReady=0, outputs stable; OutReady=1 -> tags 1,2,3 out in order, 1/cycle.
//  Flush with 2 entries in flight plus InValid -> next cycle OutValid=0, nothing emitted,
//   new entry accepted the cycle after.
//  reset_n pulsed low mid-stream (async, off-edge) -> OutValid=0 and outputs 0 immediately;
//   repeat the full set of checks with STAGES=1 and STAGES=4.

Source files
------------

// File: rtl/shiftcorr_pipe.sv
// shiftcorr_pipe: LZA overshift / divsqrt range correction ahead of an elastic STAGES-deep valid/ready pipeline
module shiftcorr_pipe #(
  parameter int NSH = 110,
  parameter int NE = 11,
  parameter int STAGES = 2,
  parameter int TAGW = 5,
  localparam int CSH = NSH - 3,
  localparam int EW = NE + 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            Flush,
  input  logic            InValid,
  output logic            InReady,
  input  logic [TAGW-1:0] InTag,
  input  logic [1:0]      Op,
  input  logic [NSH-1:0]  Shifted,
  input  logic [EW-1:0]   NormSumExp,
  input  logic            FmaPreSubnorm,
  input  logic            FmaSZero,
  input  logic [EW-1:0]   DivUe,
  input  logic            DivResSubnorm,
  input  logic            DivShiftPos,
  output logic            OutValid,
  input  logic            OutReady,
  output logic [TAGW-1:0] OutTag,
  output logic [CSH-1:0]  Mf,
  output logic [EW-1:0]   FmaMe,
  output logic [EW-1:0]   Ue,
  output logic [1:0]      Corr
);
  localparam int W = TAGW + CSH + 2 * EW + 2;
  logic [1:0] corr;
  logic [CSH-1:0] win, mf;
  logic [EW-1:0] fme, ue;
  logic pass, res_sub, acc;
  logic [STAGES-1:0] v, adv, ld;
  logic [W-1:0] d [STAGES];
  always_comb begin
    corr = Shifted[NSH-1] ? 2'd2 : Shifted[NSH-2] ? 2'd1 : 2'd0;
    win = corr == 2'd2 ? Shifted[NSH-2:2] : corr == 2'd1 ? Shifted[NSH-3:1] : Shifted[NSH-4:0];
    pass = Op[1];
    mf = (pass | (Op[0] & DivResSubnorm)) ? Shifted[NSH-1:3] : win;
    res_sub = FmaPreSubnorm & (corr == 2'd0) & ~Shifted[NSH-3];
    fme = (pass | FmaSZero | res_sub) ? '0 : NormSumExp + EW'(corr) + EW'(FmaPreSubnorm);
    ue = (pass | (DivResSubnorm & DivShiftPos)) ? '0 : DivUe - EW'(corr == 2'd0);
  end
  // a stage moves unless it and every stage after it are full while the consumer stalls
  for (genvar i = 0; i < STAGES; i++) begin : g_adv
    assign adv[i] = v[i] & (OutReady | ~&v[STAGES-1:i]);
  end
  assign InReady = ~Flush & (~v[0] | adv[0]);
  assign acc = InValid & InReady;
  assign ld = (adv << 1) | STAGES'(acc);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      v <= '0;
      for (int k = 0; k < STAGES; k++) d[k] <= '0;
    end else begin
      v <= Flush ? '0 : ld | (v & ~adv);
      if (ld[0]) d[0] <= {InTag, mf, fme, ue, corr};
      for (int k = 1; k < STAGES; k++) if (ld[k]) d[k] <= d[k-1];
    end
  assign OutValid = v[STAGES-1];
  assign {OutTag, Mf, FmaMe, Ue, Corr} = d[STAGES-1];
endmodule
